// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes, ALU and mux selects.
// The HALT state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  localparam int NONE_UNUSED_W = 6;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_HALT   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_RA  = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  typedef struct packed {
    logic r_alu;
    logic ori;
    logic load;
    logic store;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } instr_class_t;

  // R-type ALU operation carried alongside the class so the FSM never looks at funct.
  function automatic logic [1:0] r_alu_op_of(input logic [5:0] funct);
    logic [1:0] op;
    if (funct == FN_SUBU) begin
      op = ALU_SUB;
    end else begin
      op = ALU_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the FSM (master) and the MIPS datapath (slave).
interface mc_ctrl_fsm_if;
  import mc_ctrl_pkg::*;

  logic [NONE_UNUSED_W-1:0] opcode;
  logic [NONE_UNUSED_W-1:0] funct;
  logic                     zero;
  logic [1:0]               ALUOp;
  logic                     alu_src;
  logic                     ext_op;
  logic [1:0]               reg_dst;
  logic [1:0]               wd_sel;
  logic [1:0]               npc_sel;
  logic                     pc_write;
  logic                     ir_write;
  logic                     reg_write;
  logic                     mem_write;
  logic                     instr_done;
  logic                     illegal;

  modport master (
    input  opcode, funct, zero,
    output ALUOp, alu_src, ext_op, reg_dst, wd_sel, npc_sel,
           pc_write, ir_write, reg_write, mem_write, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  ALUOp, alu_src, ext_op, reg_dst, wd_sel, npc_sel,
           pc_write, ir_write, reg_write, mem_write, instr_done, illegal
  );

endinterface

// File: rtl/mc_decode.sv
// Opcode/funct to one-hot instruction class; an all-zero opcode+funct is the nop.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [NONE_UNUSED_W-1:0] opcode,
  input  logic [NONE_UNUSED_W-1:0] funct,
  output instr_class_t             cls,
  output logic [1:0]               r_alu_op
);

  // Exactly one class bit is set for every opcode/funct pair.
  always_comb begin
    cls      = '0;
    r_alu_op = r_alu_op_of(funct);
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.r_alu   = 1'b1;
          FN_JR:            cls.jr      = 1'b1;
          FN_NOP:           cls.nop     = 1'b1;
          default:          cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LW:   cls.load    = 1'b1;
      OP_SW:   cls.store   = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM driving ALUOp, write enables and mux selects.
// Define MC_ILLEGAL_TRAP_EN to trap illegal instructions in a sticky HALT state.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  instr_class_t cls;
  logic [1:0]   r_op;
  state_t       state_q;
  state_t       state_d;
  logic [1:0]   alu_op;
  logic         alu_src;
  logic         ext_op;
  logic [1:0]   reg_dst;
  logic [1:0]   wd_sel;
  logic [1:0]   npc_sel;
  logic         pc_we;
  logic         ir_we;
  logic         reg_we;
  logic         mem_we;
  logic         done;
`ifdef MC_ILLEGAL_TRAP_EN
  logic         illegal_q;
  logic         illegal_d;
`endif

  mc_decode u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .cls      (cls),
    .r_alu_op (r_op)
  );

  // Next-state and per-state control outputs; pc_write in BRANCH follows zero directly.
  always_comb begin
    state_d = state_q;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    reg_dst = RDST_RT;
    wd_sel  = WD_ALU;
    npc_sel = NPC_PC4;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls.r_alu) begin
          state_d = ST_EXEC_R;
        end else if (cls.ori) begin
          state_d = ST_EXEC_I;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM_ADDR;
        end else if (cls.beq) begin
          state_d = ST_BRANCH;
        end else if (cls.j || cls.jal || cls.jr) begin
          state_d = ST_JUMP;
        end else if (cls.nop) begin
          state_d = ST_FETCH;
          done    = 1'b1;
        end else if (cls.illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
          done    = 1'b1;
`endif
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        alu_op  = r_op;
        state_d = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_op  = ALU_OR;
        alu_src = 1'b1;
        state_d = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_we  = 1'b1;
        reg_dst = cls.r_alu ? RDST_RD : RDST_RT;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        if (cls.load) begin
          state_d = ST_MEM_RD;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_we  = 1'b1;
        wd_sel  = WD_MEM;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_we  = 1'b1;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op  = ALU_SUB;
        npc_sel = NPC_BR;
        pc_we   = bus.zero;
        done    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we   = 1'b1;
        done    = 1'b1;
        state_d = ST_FETCH;
        if (cls.jr) begin
          npc_sel = NPC_RS;
        end else begin
          npc_sel = NPC_JMP;
          if (cls.jal) begin
            reg_we  = 1'b1;
            reg_dst = RDST_RA;
            wd_sel  = WD_PC4;
          end else begin
            reg_we  = 1'b0;
          end
        end
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  // Sticky trap flag: set on the DECODE cycle that sees an illegal class.
  always_comb begin
    if ((state_q == ST_DECODE) && cls.illegal) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end
`endif

  // State register; reset returns to FETCH asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Enables are gated by reset so nothing is written while it is held.
  assign bus.ALUOp      = alu_op;
  assign bus.alu_src    = alu_src;
  assign bus.ext_op     = ext_op;
  assign bus.reg_dst    = reg_dst;
  assign bus.wd_sel     = wd_sel;
  assign bus.npc_sel    = npc_sel;
  assign bus.pc_write   = pc_we  & ~reset;
  assign bus.ir_write   = ir_we  & ~reset;
  assign bus.reg_write  = reg_we & ~reset;
  assign bus.mem_write  = mem_we & ~reset;
  assign bus.instr_done = done   & ~reset;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal    = illegal_q & ~reset;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a per-instruction cycle model pushes expected
// control vectors; a negedge monitor pops and compares them every cycle.
module tb_mc_ctrl_fsm;

  typedef logic [15:0] vec_t;

  logic clk;
  logic reset;
  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  trace_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic vec_t mk(input logic [1:0] alu, input logic src, input logic ext,
                              input logic [1:0] rdst, input logic [1:0] wsel,
                              input logic [1:0] nsel, input logic pcw, input logic irw,
                              input logic rw, input logic mw, input logic done,
                              input logic ill);
    return {alu, src, ext, rdst, wsel, nsel, pcw, irw, rw, mw, done, ill};
  endfunction

  function automatic string kind_of(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'h0000_0000) return "nop";
    if (op == 6'h00) begin
      if (fn == 6'h21) return "addu";
      if (fn == 6'h23) return "subu";
      if (fn == 6'h08) return "jr";
      return "ill";
    end
    if (op == 6'h0d) return "ori";
    if (op == 6'h23) return "lw";
    if (op == 6'h2b) return "sw";
    if (op == 6'h04) return "beq";
    if (op == 6'h02) return "j";
    if (op == 6'h03) return "jal";
    return "ill";
  endfunction

  // Expected control vector for every cycle of one instruction, FETCH first.
  function automatic void model(input logic [31:0] ins, input logic z);
    string k;
    vec_t  idle;
    k    = kind_of(ins);
    idle = mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    trace_q.delete();
    trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    if (k == "nop") begin
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (k == "addu" || k == "subu") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk((k == "subu") ? 2'b01 : 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else if (k == "ori") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else if (k == "lw" || k == "sw") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (k == "lw") begin
        trace_q.push_back(idle);
        trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      end else begin
        trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      end
    end else if (k == "beq") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (k == "j") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (k == "jal") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else if (k == "jr") begin
      trace_q.push_back(idle);
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      trace_q.push_back(idle);
      for (int i = 0; i < 20; i++) begin
        trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end
`else
      trace_q.push_back(mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
`endif
    end
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_ill);
    logic [31:0] w;
    logic [5:0]  op;
    logic [5:0]  fn;
    w = $urandom();
    case ($urandom_range(0, allow_ill ? 10 : 9))
      0: w = 32'h0000_0000;
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      2: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      3: w[31:26] = 6'h0d;
      4: w[31:26] = 6'h23;
      5: w[31:26] = 6'h2b;
      6: w[31:26] = 6'h04;
      7: w[31:26] = 6'h02;
      8: w[31:26] = 6'h03;
      9: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      default: begin
        op = 6'($urandom_range(0, 63));
        if (op inside {6'h0d, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03}) op = 6'h3f;
        fn = w[5:0];
        if (op == 6'h00 && (fn inside {6'h21, 6'h23, 6'h08, 6'h00})) fn = 6'h3f;
        w[31:26] = op;
        w[5:0]   = fn;
      end
    endcase
    return w;
  endfunction

  task automatic push_trace(input logic [31:0] ins, input int cut);
    for (int i = 0; i < cut; i++) begin
      exp_q.push_back(trace_q[i]);
      tag_q.push_back($sformatf("%s_%08h_c%0d", kind_of(ins), ins, i));
    end
  endtask

  // Issue one instruction, optionally truncating it to 'cut' cycles (cut<0 = whole).
  task automatic run_instr(input logic [31:0] ins, input logic z, input int cut);
    int n;
    model(ins, z);
    n = (cut < 0) ? trace_q.size() : cut;
    bus.opcode = ins[31:26];
    bus.funct  = ins[5:0];
    bus.zero   = z;
    push_trace(ins, n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(16'h0000);
      tag_q.push_back($sformatf("reset_c%0d", i));
    end
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Monitor: compare the full control vector against the scoreboard each cycle.
  always @(negedge clk) begin
    vec_t  e;
    vec_t  act;
    string t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {bus.ALUOp, bus.alu_src, bus.ext_op, bus.reg_dst, bus.wd_sel, bus.npc_sel,
             bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.instr_done,
             bus.illegal};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %04h expected %04h (alu,src,ext,rdst,wsel,nsel,pcw,irw,rw,mw,done,ill)",
                 t, act, e);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    @(posedge clk);
    #1;
    hold_reset(2);

    run_instr(32'h0085_1021, 1'b0, -1);   // addu
    run_instr(32'h8C88_0004, 1'b0, -1);   // lw
    run_instr(32'hAC88_0004, 1'b1, -1);   // sw
    run_instr(32'h1085_0003, 1'b1, -1);   // beq taken
    run_instr(32'h1085_0003, 1'b0, -1);   // beq not taken
    run_instr(32'h0C00_0010, 1'b0, -1);   // jal
    run_instr(32'h03E0_0008, 1'b1, -1);   // jr
    run_instr(32'h0800_0010, 1'b0, -1);   // j
    run_instr(32'h34A5_FFFF, 1'b0, -1);   // ori
    run_instr(32'h0085_1023, 1'b1, -1);   // subu
    run_instr(32'h0000_0000, 1'b1, -1);   // nop

    run_instr(32'h8C88_0004, 1'b0, 3);    // reset while in MEM_RD
    hold_reset(2);
    run_instr(32'h0000_0000, 1'b0, -1);
    run_instr(32'h8C88_0004, 1'b0, 4);    // reset while in MEM_WB
    hold_reset(1);
    run_instr(32'h0085_1021, 1'b0, 3);    // reset while in ALU_WB
    hold_reset(2);
    run_instr(32'h0085_1021, 1'b0, -1);

`ifdef MC_ILLEGAL_TRAP_EN
    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(1'b0), 1'($urandom_range(0, 1)), -1);
    end
    run_instr(32'hFC00_0000, 1'b0, -1);   // trap into HALT
    hold_reset(2);
    run_instr(32'h0000_0000, 1'b0, -1);
    run_instr(32'hAC88_0004, 1'b0, -1);
`else
    run_instr(32'hFC00_0000, 1'b0, -1);   // illegal behaves as nop
    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(1'b1), 1'($urandom_range(0, 1)), -1);
    end
`endif

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
